glitch_clk_multi: RTL and testbench
===================================

GLITCH_CLK_MULTI -- requirements
Module: glitch_clk_multi

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle-count inputs and counters.
REQ-002 SHALL have parameter MAX_BURSTS, default 8, upper bound applied to the bursts input.
REQ-003 SHALL have port clk  input  1  fast glitch clock; all state advances on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trig  input  1  arm request, clk domain, rising-edge sensitive.
REQ-006 SHALL have port clean_target_clock  input  1  undisturbed target clock, asynchronous to clk.
REQ-007 SHALL have port mode  input  1  0 = inject fast clk cycles, 1 = drop target cycles (hold low).
REQ-008 SHALL have port delay  input  CNT_W  target cycles skipped between arm and first burst.
REQ-009 SHALL have port width  input  CNT_W  clk cycles per burst (mode 0) or target cycles dropped per burst (mode 1).
REQ-010 SHALL have port gap  input  CNT_W  clean target cycles between bursts.
REQ-011 SHALL have port bursts  input  CNT_W  bursts per trigger; 0 treated as 1, values >MAX_BURSTS clamped to MAX_BURSTS.
REQ-012 SHALL have port clk_o  output  1  glitched target clock.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-clk pulse when the last burst ends.
REQ-015 SHALL have port glitch_count  output  16  completed sequences (see Configuration).

Function
REQ-016 SHALL synchronise clean_target_clock through two clk flops; a "target edge" is a 0->1 transition of the synchronised copy (detection latency 2-3 clk).
REQ-017 SHALL implement states IDLE, DELAY, ACTIVE, GAP, RECOVER, HOLD.
REQ-018 SHALL latch delay, width, gap, bursts (after clamp) and mode on the clk edge where trig rises in IDLE; later input changes SHALL NOT affect the running sequence.
REQ-019 IDLE -> DELAY on trig rising edge; trig edges outside IDLE SHALL be ignored.
REQ-020 DELAY SHALL count target edges; on the delay-th edge (immediately on the next target edge if delay=0) -> ACTIVE.
REQ-021 ACTIVE mode 0: clk_o = clk for exactly width clk cycles, then -> RECOVER; width=0 SHALL skip ACTIVE directly to RECOVER.
REQ-022 ACTIVE mode 1: clk_o = 0 for width target edges, then -> RECOVER.
REQ-023 RECOVER: clk_o = 0 until next target edge; then -> GAP if bursts remain, else -> HOLD with done pulse.
REQ-024 GAP: clk_o = clean_target_clock; after gap target edges -> ACTIVE; gap=0 SHALL go to ACTIVE on the same edge that leaves RECOVER.
REQ-025 HOLD: clk_o = clean_target_clock; -> IDLE when trig is low.
REQ-026 In IDLE and DELAY clk_o SHALL equal clean_target_clock combinationally.
REQ-027 All counters SHALL saturate, never wrap; the burst counter SHALL count down from the latched value to 0.
REQ-028 If trig rises on the same clk edge as a HOLD->IDLE transition, the edge SHALL be ignored (re-arm requires a fresh rising edge).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, all counters 0, busy 0, done 0, glitch_count 0; clk_o then follows clean_target_clock.
REQ-030 Reset asserted mid-sequence SHALL abort without emitting done and without incrementing glitch_count.
REQ-031 Synchroniser flops SHALL reset to 0, so a target already high at release produces no spurious edge.

Configuration
REQ-032 Macro GLITCH_COUNT_EN defined: glitch_count SHALL increment (saturating at 16'hFFFF) on each done pulse.
REQ-033 Macro GLITCH_COUNT_EN undefined: glitch_count SHALL be tied to 0 and the counter SHALL NOT be synthesised.

Verification
REQ-034 mode=0, delay=3, width=5, bursts=1, gap=0, trig rise -> exactly 5 clk pulses on clk_o starting after 3rd target edge, then low until next edge, done pulse once.
REQ-035 mode=1, delay=0, width=2, bursts=3, gap=4 -> three 2-target-cycle dropouts separated by 4 clean cycles, one done, busy high throughout.
REQ-036 bursts=0 vs bursts=1 -> identical clk_o waveforms; bursts=20 with MAX_BURSTS=8 -> 8 bursts.
REQ-037 rst_n low during ACTIVE burst 2 of 3 -> clk_o returns to clean_target_clock immediately, no done, glitch_count unchanged.
REQ-038 trig held high after done, toggled again mid-HOLD -> no second sequence; trig low then high -> new sequence, glitch_count=2 with GLITCH_COUNT_EN, 0 without.

Source files
------------

// File: rtl/glitch_clk_multi.sv
// Multi-burst clock glitcher: injects fast clk cycles or drops target cycles on clk_o.
// Optional sequence counter enabled by defining GLITCH_COUNT_EN.
module glitch_clk_multi #(
    parameter int CNT_W      = 16,
    parameter int MAX_BURSTS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             clean_target_clock,
    input  logic             mode,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [CNT_W-1:0] bursts,
    output logic             clk_o,
    output logic             busy,
    output logic             done,
    output logic [15:0]      glitch_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_GAP     = 3'd3,
        ST_RECOVER = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURSTS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // True when the event being counted now is the lim-th one (lim=0 behaves as 1).
    function automatic logic reached(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] lim);
        return (sat_inc(cnt) >= lim);
    endfunction

    function automatic logic [CNT_W-1:0] clamp_bursts(input logic [CNT_W-1:0] b);
        if (b == CNT_ZERO) begin
            return CNT_ONE;
        end else if (b > BURST_MAX) begin
            return BURST_MAX;
        end else begin
            return b;
        end
    endfunction

    logic             sync1_r, sync2_r, sync3_r;
    logic             trig_d_r;
    state_t           state_r, state_s;
    logic             mode_r;
    logic [CNT_W-1:0] delay_r, width_r, gap_r;
    logic [CNT_W-1:0] bursts_left_r, bursts_left_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, done_r, done_s;
    logic             latch_s;
    logic             gate_n_r;
    logic             clk_o_s;
    logic             edge_s;
    logic             trig_rise_s;
    state_t           burst_entry_s;

    assign edge_s        = sync2_r & ~sync3_r;
    assign trig_rise_s   = trig & ~trig_d_r;
    assign burst_entry_s = (width_r == CNT_ZERO) ? ST_RECOVER : ST_ACTIVE;

    // Target clock synchroniser and trig edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            sync3_r  <= 1'b0;
            trig_d_r <= 1'b0;
        end else begin
            sync1_r  <= clean_target_clock;
            sync2_r  <= sync1_r;
            sync3_r  <= sync2_r;
            trig_d_r <= trig;
        end
    end

    // Next-state, counter and burst bookkeeping.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        bursts_left_s = bursts_left_r;
        latch_s       = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trig_rise_s) begin
                    latch_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_DELAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (edge_s && reached(cnt_r, delay_r)) begin
                    cnt_s   = CNT_ZERO;
                    state_s = burst_entry_s;
                end else if (edge_s) begin
                    cnt_s = sat_inc(cnt_r);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_ACTIVE: begin
                // Mode 0 counts fast clk cycles, mode 1 counts dropped target edges.
                if ((!mode_r || edge_s) && reached(cnt_r, width_r)) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_RECOVER;
                end else if (!mode_r || edge_s) begin
                    cnt_s = sat_inc(cnt_r);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_RECOVER: begin
                if (edge_s && (bursts_left_r > CNT_ONE)) begin
                    cnt_s         = CNT_ZERO;
                    bursts_left_s = bursts_left_r - CNT_ONE;
                    state_s       = (gap_r == CNT_ZERO) ? burst_entry_s : ST_GAP;
                end else if (edge_s) begin
                    cnt_s         = CNT_ZERO;
                    bursts_left_s = CNT_ZERO;
                    done_s        = 1'b1;
                    state_s       = ST_HOLD;
                end else begin
                    state_s = ST_RECOVER;
                end
            end
            ST_GAP: begin
                if (edge_s && reached(cnt_r, gap_r)) begin
                    cnt_s   = CNT_ZERO;
                    state_s = burst_entry_s;
                end else if (edge_s) begin
                    cnt_s = sat_inc(cnt_r);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_HOLD: begin
                if (!trig) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counters, latched configuration and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            bursts_left_r <= CNT_ZERO;
            mode_r        <= 1'b0;
            delay_r       <= CNT_ZERO;
            width_r       <= CNT_ZERO;
            gap_r         <= CNT_ZERO;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= done_s;
            if (latch_s) begin
                mode_r        <= mode;
                delay_r       <= delay;
                width_r       <= width;
                gap_r         <= gap;
                bursts_left_r <= clamp_bursts(bursts);
            end else begin
                bursts_left_r <= bursts_left_s;
            end
        end
    end

    // Fast-clock enable changes only while clk is low so injected pulses are never truncated.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_n_r <= 1'b0;
        end else begin
            gate_n_r <= (state_r == ST_ACTIVE) && !mode_r;
        end
    end

    // Output clock selection.
    always_comb begin
        clk_o_s = clean_target_clock;
        case (state_r)
            ST_IDLE, ST_DELAY, ST_GAP, ST_HOLD: clk_o_s = clean_target_clock;
            ST_ACTIVE:  clk_o_s = mode_r ? 1'b0 : (clk & gate_n_r);
            ST_RECOVER: clk_o_s = clk & gate_n_r;
            default:    clk_o_s = clean_target_clock;
        endcase
    end

    assign clk_o = clk_o_s;
    assign busy  = busy_r;
    assign done  = done_r;

`ifdef GLITCH_COUNT_EN
    logic [15:0] glitch_cnt_r;

    // Completed-sequence counter, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_r <= 16'h0000;
        end else if (done_s && (glitch_cnt_r != 16'hFFFF)) begin
            glitch_cnt_r <= glitch_cnt_r + 16'h0001;
        end else begin
            glitch_cnt_r <= glitch_cnt_r;
        end
    end

    assign glitch_count = glitch_cnt_r;
`else
    assign glitch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_glitch_clk_multi.sv
// Directed + randomized bench for glitch_clk_multi with a pulse-counting reference model.
module tb_glitch_clk_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic        clean_target_clock = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] delay = 16'd0, width = 16'd0, gap = 16'd0, bursts = 16'd0;
    logic        clk_o, busy, done;
    logic [15:0] glitch_count;

    int errors = 0;
    int checks = 0;
    int fast_cnt = 0, slow_cnt = 0, clean_cnt = 0;
    bit cnt_en = 1'b0;
    int model_seq = 0;
    int last_fast = 0;

    glitch_clk_multi #(.CNT_W(16), .MAX_BURSTS(8)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .clean_target_clock(clean_target_clock),
        .mode(mode), .delay(delay), .width(width), .gap(gap), .bursts(bursts),
        .clk_o(clk_o), .busy(busy), .done(done), .glitch_count(glitch_count)
    );

    // clk rises at 5 mod 10; target edges land at 2 mod 10 while clk is low
    always #5 clk = ~clk;
    initial begin
        #12;
        forever begin
            clean_target_clock = ~clean_target_clock;
            #40;
        end
    end

    // Rises aligned with a fast clk edge are glitch/rejoin edges; the rest are passed target edges
    always @(posedge clk_o) if (cnt_en) begin
        if (clk) fast_cnt++;
        else slow_cnt++;
    end
    always @(posedge clean_target_clock) if (cnt_en) clean_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_gc();
`ifdef GLITCH_COUNT_EN
        return (model_seq > 65535) ? 65535 : model_seq;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string tag, input bit m, input int d, input int w,
                           input int g, input int b, input bit keep_trig);
        int be, de, rejoin, busy_low;
        int exp_fast, exp_slow, exp_clean;
        bit got;
        mode = m; delay = 16'(d); width = 16'(w); gap = 16'(g); bursts = 16'(b);
        @(negedge clean_target_clock);
        tick();
        fast_cnt = 0; slow_cnt = 0; clean_cnt = 0; cnt_en = 1'b1;
        trig = 1'b1;
        tick();
        // scramble inputs after arming: the running sequence must ignore them
        mode = ~m; delay = 16'($urandom_range(1, 9)); width = 16'($urandom_range(0, 9));
        gap = 16'($urandom_range(0, 9)); bursts = 16'($urandom_range(0, 30));
        busy_low = 0; got = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
            if (busy !== 1'b1) busy_low++;
            if (done === 1'b1) got = 1'b1;
            else tick();
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        tick();
        cnt_en = 1'b0;
        be = (b == 0) ? 1 : ((b > 8) ? 8 : b);
        de = (d == 0) ? 1 : d;
        rejoin = 1 + ((g > 0) ? be - 1 : 0);
        exp_fast  = (m ? 0 : be * w) + rejoin;
        exp_slow  = de + (be - 1) * g;
        exp_clean = m ? de + be * (w + 1) + (be - 1) * g : de + be + (be - 1) * g;
        check({tag, "_fast"}, 32'(fast_cnt), 32'(exp_fast));
        check({tag, "_slow"}, 32'(slow_cnt), 32'(exp_slow));
        check({tag, "_target_cycles"}, 32'(clean_cnt), 32'(exp_clean));
        check({tag, "_busy_low"}, 32'(busy_low), 32'd0);
        if (got) model_seq++;
        check({tag, "_gcount"}, 32'(glitch_count), 32'(exp_gc()));
        last_fast = fast_cnt;
        if (!keep_trig) begin
            trig = 1'b0;
            repeat (3) tick();
            check({tag, "_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int done_hi;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gcount", 32'(glitch_count), 32'd0);
        check("rst_clko_lo", 32'(clk_o), 32'(clean_target_clock));
        #12;
        check("rst_clko_hi", 32'(clk_o), 32'(clean_target_clock));
        #20 rst_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", 32'(busy), 32'd0);

        run_seq("m0_d3_w5", 1'b0, 3, 5, 0, 1, 1'b0);
        run_seq("m1_d0_w2_b3", 1'b1, 0, 2, 4, 3, 1'b0);
        run_seq("b0", 1'b0, 2, 3, 1, 0, 1'b0);
        done_hi = last_fast;
        run_seq("b1", 1'b0, 2, 3, 1, 1, 1'b0);
        check("b0_vs_b1", 32'(last_fast), 32'(done_hi));
        run_seq("b20", 1'b1, 1, 1, 1, 20, 1'b0);
        run_seq("w0", 1'b0, 1, 0, 2, 2, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_seq($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 10), 1'b0);
        end

        // reset while the second of three dropout bursts is active
        mode = 1'b1; delay = 16'd1; width = 16'd2; gap = 16'd1; bursts = 16'd3;
        @(negedge clean_target_clock);
        tick();
        trig = 1'b1;
        repeat (6) @(posedge clean_target_clock);
        #30;
        check("pre_rst_clko", 32'(clk_o), 32'd0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        trig = 1'b0;
        #1;
        check("abort_clko", 32'(clk_o), 32'(clean_target_clock));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_gcount", 32'(glitch_count), 32'd0);
        model_seq = 0;
        @(negedge clean_target_clock);
        #1;
        check("abort_clko_lo", 32'(clk_o), 32'(clean_target_clock));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // trig held high through HOLD must not re-arm
        run_seq("rearm1", 1'b0, 1, 2, 0, 2, 1'b1);
        done_hi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) done_hi++;
        end
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_no_done", 32'(done_hi), 32'd0);
        trig = 1'b0;
        repeat (3) tick();
        check("hold_exit", 32'(busy), 32'd0);
        run_seq("rearm2", 1'b1, 0, 1, 1, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
